// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer, flush and nop.
// Optional saturating stall/bubble counters are enabled with `define PIPE_PERF_CNT_EN.
module pipe_stage_reg #(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 29,
  parameter int PC_W   = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              nop,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and a held entry stays stable until it is taken.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic              w_main_v;
  logic              w_skid_v;
  logic              w_acc;
  logic              w_drn;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;
  logic [CTRL_W-1:0] w_in_ctrl;

  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [PC_W-1:0]   r_main_pc;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [PC_W-1:0]   r_skid_pc;

  assign w_main_v  = (r_state != S_EMPTY);
  assign w_skid_v  = (r_state == S_FULL);
  // Ready comes straight from the skid flop; only reset gates it.
  assign in_ready  = ~w_skid_v & ~rst;
  assign w_acc     = in_valid & in_ready & ~flush;
  assign w_drn     = w_main_v & out_ready;
  assign w_in_ctrl = nop ? '0 : in_ctrl;

  assign out_valid = w_main_v;
  assign out_ctrl  = w_main_v ? r_main_ctrl : '0;
  assign out_data  = r_main_data;
  assign out_pc    = r_main_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            w_state_next   = S_ONE;
            w_load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_acc && w_drn) begin
            w_load_main_in = 1'b1;
          end else if (w_acc) begin
            w_state_next = S_FULL;
            w_load_skid  = 1'b1;
          end else if (w_drn) begin
            w_state_next = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_drn) begin
            w_state_next     = S_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_main_pc   <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_pc   <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_ctrl <= w_in_ctrl;
        r_main_data <= in_data;
        r_main_pc   <= in_pc;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
        r_main_pc   <= r_skid_pc;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= w_in_ctrl;
        r_skid_data <= in_data;
        r_skid_pc   <= in_pc;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Both counters stick at all-ones; flush leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_main_v && !out_ready && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_acc && nop && (r_bubble_cnt != '1))          r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  logic [CNT_W-1:0] w_cnt_unused;
  assign w_cnt_unused = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic checked against
// a two-deep FIFO reference model.
module tb_pipe_stage_reg;
  localparam int CTRL_W  = 24;
  localparam int DATA_W  = 29;
  localparam int PC_W    = 10;
  localparam int CNT_W   = 4;
  localparam int ENT_W   = CTRL_W + DATA_W + PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic [PC_W-1:0]   in_pc = '0;
  logic              nop = 1'b0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [PC_W-1:0]   out_pc;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
`endif

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
    .nop(nop), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_pc(out_pc)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [ENT_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] m_data;
  logic [PC_W-1:0]   m_pc;
  int                m_stall;
  int                m_bubble;
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_data   = '0;
    m_pc     = '0;
    m_stall  = 0;
    m_bubble = 0;
  endtask

  // Called at each rising edge with the inputs that were applied for that cycle.
  task automatic model_update();
    bit acc;
    bit drn;
    logic [CTRL_W-1:0] c;
    logic [ENT_W-1:0]  e;
    if (rst) return;
    acc = in_valid && (exp_q.size() < 2) && !flush;
    drn = (exp_q.size() > 0) && out_ready;
    if ((exp_q.size() > 0) && !out_ready && (m_stall < CNT_MAX)) m_stall++;
    if (acc && nop && (m_bubble < CNT_MAX)) m_bubble++;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (drn) void'(exp_q.pop_front());
      if (acc) begin
        c = nop ? '0 : in_ctrl;
        exp_q.push_back({c, in_data, in_pc});
      end
    end
    if (exp_q.size() > 0) begin
      e      = exp_q[0];
      m_data = e[PC_W +: DATA_W];
      m_pc   = e[PC_W-1:0];
    end
  endtask

  task automatic check_outputs();
    logic [ENT_W-1:0]  e;
    logic [CTRL_W-1:0] ec;
    ec = '0;
    if (exp_q.size() > 0) begin
      e  = exp_q[0];
      ec = e[ENT_W-1 -: CTRL_W];
    end
    check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    check_eq("out_ctrl",  64'(out_ctrl),  64'(ec));
    check_eq("out_data",  64'(out_data),  64'(m_data));
    check_eq("out_pc",    64'(out_pc),    64'(m_pc));
    check_eq("in_ready",  64'(in_ready),  64'(!rst && (exp_q.size() < 2)));
`ifdef PIPE_PERF_CNT_EN
    check_eq("stall_cnt",  64'(stall_cnt),  64'(m_stall));
    check_eq("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`endif
  endtask

  // driver: apply inputs (called just after a falling edge), run one cycle, check
  task automatic cycle(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic [PC_W-1:0] p, input logic n, input logic f, input logic r);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    in_pc     = p;
    nop       = n;
    flush     = f;
    out_ready = r;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, r);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    nop       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_in_ready",  64'(in_ready),  64'(0));
      check_eq("rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("rst_out_ctrl",  64'(out_ctrl),  64'(0));
    end
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    model_clear();
    do_reset();

    // streaming at full rate
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 24'hABCDEF, DATA_W'($urandom), PC_W'(i), 1'b0, 1'b0, 1'b1);
      check_eq("stream_pc", 64'(out_pc), 64'(i));
      check_eq("stream_in_ready", 64'(in_ready), 64'(1));
    end
    idle(1'b1);

    // fill skid, hold, then drain in order
    cycle(1'b1, 24'h000111, 29'h55, 10'd5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 24'h000222, 29'h66, 10'd6, 1'b0, 1'b0, 1'b0);
    check_eq("full_in_ready", 64'(in_ready), 64'(0));
    check_eq("full_pc", 64'(out_pc), 64'(5));
    cycle(1'b1, 24'h000333, 29'h77, 10'd7, 1'b0, 1'b0, 1'b0);
    check_eq("full_hold_pc", 64'(out_pc), 64'(5));
    check_eq("full_hold_ctrl", 64'(out_ctrl), 64'(24'h000111));
    idle(1'b1);
    check_eq("drain_pc6", 64'(out_pc), 64'(6));
    check_eq("drain_in_ready", 64'(in_ready), 64'(1));
    idle(1'b1);
    check_eq("drained_valid", 64'(out_valid), 64'(0));

    // nop turns the entry into a bubble but keeps data
    cycle(1'b1, 24'hFFFFFF, 29'h1234, 10'd9, 1'b1, 1'b0, 1'b0);
    check_eq("nop_ctrl", 64'(out_ctrl), 64'(0));
    check_eq("nop_data", 64'(out_data), 64'(29'h1234));
`ifdef PIPE_PERF_CNT_EN
    check_eq("nop_bubble_cnt", 64'(bubble_cnt), 64'(1));
`endif

    // flush while full drops everything, including the offered entry
    cycle(1'b1, 24'h0000AA, 29'hAA, 10'd10, 1'b0, 1'b0, 1'b0);
    check_eq("pre_flush_in_ready", 64'(in_ready), 64'(0));
    cycle(1'b1, 24'h0000BB, 29'hBB, 10'd11, 1'b0, 1'b1, 1'b0);
    check_eq("flush_valid", 64'(out_valid), 64'(0));
    check_eq("flush_in_ready", 64'(in_ready), 64'(1));
    repeat (3) idle(1'b1);

    // stall counter saturation
    do_reset();
    cycle(1'b1, 24'h00C0DE, 29'h1, 10'd1, 1'b0, 1'b0, 1'b0);
    repeat ((1 << CNT_W) + 3) idle(1'b0);
`ifdef PIPE_PERF_CNT_EN
    check_eq("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
`endif
    check_eq("stall_hold_pc", 64'(out_pc), 64'(1));

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), CTRL_W'($urandom), DATA_W'($urandom),
            PC_W'($urandom_range(0, 1023)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end

    // reset mid-operation takes effect without a clock edge
    cycle(1'b1, 24'h123456, 29'h3, 10'd3, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 24'h654321, 29'h4, 10'd4, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 64'(out_valid), 64'(0));
    check_eq("async_rst_ctrl",  64'(out_ctrl),  64'(0));
    check_eq("async_rst_data",  64'(out_data),  64'(0));
    check_eq("async_rst_pc",    64'(out_pc),    64'(0));
    check_eq("async_rst_ready", 64'(in_ready),  64'(0));
    model_clear();
    do_reset();
    repeat (4) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
